// File: rtl/uart_tx_arb.sv
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin arbiter that shares one uart_tx serializer
//               between NUM_REQ byte producers (valid/ready handshake).
//               Optional message lock is enabled by defining the macro
//               UART_TX_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       synchronous reset, active low
//   req_valid_i  per-requester byte offer
//   req_data_i   per-requester byte, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i   per-requester end-of-message flag (lock build only)
//   req_ready_o  one-hot acceptance pulse (combinational, IDLE only)
//   tx_wr_en_o   one-cycle write strobe to uart_tx
//   tx_din_o     registered byte to uart_tx
//   tx_busy_i    busy flag from uart_tx
//   grant_id_o   index of the most recently accepted requester
//   arb_busy_o   high whenever the FSM is not in IDLE
// ============================================================================
`default_nettype none

module uart_tx_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]              req_last_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            tx_wr_en_o,
  output logic [DATA_WIDTH-1:0]           tx_din_o,
  input  logic                            tx_busy_i,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id_o,
  output logic                            arb_busy_o
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e                state_q;
  logic [PW-1:0]         rr_ptr_q;
  logic [PW-1:0]         grant_id_q;
  logic [DATA_WIDTH-1:0] tx_din_q;
  logic                  tx_wr_en_q;
  logic                  arb_busy_q;

  logic [PW-1:0]         win_idx_d;
  logic                  win_found_d;
  logic [PW:0]           scan_idx_d;
  logic [PW-1:0]         rr_ptr_d;
  logic [DATA_WIDTH-1:0] win_data_d;
  logic                  grant_d;

`ifdef UART_TX_ARB_LOCK_EN
  logic                  lock_q;
  logic [PW-1:0]         lock_id_q;
`else
  logic                  unused_last;
  assign unused_last = ^req_last_i;
`endif

  // Winner search: scan upward from rr_ptr with explicit wrap. The loop runs
  // from the far end down so the closest valid requester is written last.
  // The extra MSB of scan_idx_d holds rr_ptr + k before the wrap subtraction,
  // which keeps the result correct for non-power-of-2 NUM_REQ.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    scan_idx_d  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx_d = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (scan_idx_d >= (PW+1)'(NUM_REQ)) begin
        scan_idx_d = scan_idx_d - (PW+1)'(NUM_REQ);
      end
      if (req_valid_i[scan_idx_d[PW-1:0]]) begin
        win_found_d = 1'b1;
        win_idx_d   = scan_idx_d[PW-1:0];
      end
    end
`ifdef UART_TX_ARB_LOCK_EN
    // A locked message owns the serializer until its last byte goes out.
    if (lock_q) begin
      win_idx_d   = lock_id_q;
      win_found_d = req_valid_i[lock_id_q];
    end
`endif
  end

  assign win_data_d = req_data_i[int'(win_idx_d)*DATA_WIDTH +: DATA_WIDTH];
  assign rr_ptr_d   = (win_idx_d == PW'(NUM_REQ - 1)) ? '0 : win_idx_d + 1'b1;

  // Acceptance is gated by reset so req_ready reads zero while rst_ni is low.
  assign grant_d = rst_ni && (state_q == S_IDLE) && !tx_busy_i && win_found_d;

  always_comb begin
    req_ready_o = '0;
    if (grant_d) begin
      req_ready_o[win_idx_d] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_din_q   <= '0;
      tx_wr_en_q <= 1'b0;
      arb_busy_q <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_wr_en_q <= 1'b0;
          if (grant_d) begin
            tx_din_q   <= win_data_d;
            grant_id_q <= win_idx_d;
            tx_wr_en_q <= 1'b1;
            arb_busy_q <= 1'b1;
            state_q    <= S_ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
            if (req_last_i[win_idx_d]) begin
              lock_q   <= 1'b0;
              rr_ptr_q <= rr_ptr_d;
            end else begin
              lock_q    <= 1'b1;
              lock_id_q <= win_idx_d;
            end
`else
            rr_ptr_q <= rr_ptr_d;
`endif
          end
        end
        S_ISSUE: begin
          tx_wr_en_q <= 1'b0;
          state_q    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_busy_i) begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy_i) begin
            state_q    <= S_IDLE;
            arb_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tx_wr_en_q <= 1'b0;
          arb_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_wr_en_o = tx_wr_en_q;
  assign tx_din_o   = tx_din_q;
  assign grant_id_o = grant_id_q;
  assign arb_busy_o = arb_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Directed self-checking bench for uart_tx_arb with a simple
//               uart_tx busy model (busy rises the cycle after wr_en and
//               stays high for FRAME cycles). Lock expectations follow
//               UART_TX_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arb;

  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int FRAME = 4;

`ifdef UART_TX_ARB_LOCK_EN
  localparam int N3 = 5;
  localparam int        EXP_ID3 [0:6] = '{0, 1, 1, 1, 0, 0, 0};
  localparam logic [7:0] EXP_D3 [0:6] = '{8'h55, 8'hA0, 8'hA1, 8'hA2, 8'h55, 8'h00, 8'h00};
`else
  localparam int N3 = 7;
  localparam int        EXP_ID3 [0:6] = '{0, 1, 0, 1, 0, 1, 0};
  localparam logic [7:0] EXP_D3 [0:6] = '{8'h55, 8'hA0, 8'h55, 8'hA1, 8'h55, 8'hA2, 8'h55};
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          tx_wr_en;
  logic [DW-1:0] tx_din;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          arb_busy;

  logic          force_busy;
  int            busy_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // uart_tx stand-in: keeps running across an arbiter reset.
  always @(posedge clk) begin
    if (tx_wr_en)          busy_cnt <= FRAME;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  uart_tx_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_wr_en_o  (tx_wr_en),
    .tx_din_o    (tx_din),
    .tx_busy_i   (tx_busy),
    .grant_id_o  (grant_id),
    .arb_busy_o  (arb_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 60) begin
      step();
      n++;
    end
    check({tag, "_ready_seen"}, 32'(req_ready != '0), 32'd1);
  endtask

  task automatic do_grant(input string tag, input int id, input logic [7:0] d);
    wait_ready(tag);
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
    step();
    check({tag, "_wr_en"}, 32'(tx_wr_en), 32'd1);
    check({tag, "_grant_id"}, 32'(grant_id), 32'(id));
    check({tag, "_din"}, 32'(tx_din), 32'(d));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (arb_busy && n < 60) begin
      step();
      n++;
    end
    check({tag, "_idle"}, 32'(arb_busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt1;
    int n;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    force_busy = 1'b0;
    busy_cnt   = 0;

    // Reset state
    step();
    step();
    check("rst_wr_en", 32'(tx_wr_en), 32'd0);
    check("rst_din", 32'(tx_din), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    rst_n = 1'b1;
    step();

    // Single requester 2, byte 0x5A
    req_valid = 4'b0100;
    req_data  = 32'h005A0000;
    do_grant("single", 2, 8'h5A);
    req_valid = '0;
    check("single_busy_flag", 32'(arb_busy), 32'd1);
    step();
    check("single_wr_pulse", 32'(tx_wr_en), 32'd0);
    check("single_tx_busy", 32'(tx_busy), 32'd1);
    n = 0;
    while (tx_busy && n < 60) begin
      step();
      n++;
    end
    check("single_frame_end", 32'(tx_busy), 32'd0);
    check("single_busy_at_f", 32'(arb_busy), 32'd1);
    step();
    check("single_idle_f1", 32'(arb_busy), 32'd0);

    // Round robin with all four held valid
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    do_grant("rr0", 0, 8'h10);
    do_grant("rr1", 1, 8'h11);
    do_grant("rr2", 2, 8'h12);
    do_grant("rr3", 3, 8'h13);
    do_grant("rr4", 0, 8'h10);
    req_valid = '0;
    wait_idle("rr");

    // Requester 1 message of three bytes against a continuously valid requester 0
    do_reset();
    cnt1      = 0;
    req_valid = 4'b0011;
    req_data  = 32'h0000A055;
    req_last  = 4'b0001;
    for (int g = 0; g < N3; g++) begin
      do_grant("msg", EXP_ID3[g], EXP_D3[g]);
      if (grant_id == 2'd1) begin
        cnt1++;
        if (cnt1 == 3) begin
          req_valid[1] = 1'b0;
        end else begin
          req_data[15:8] = 8'hA0 + 8'(cnt1);
          req_last[1]    = (cnt1 == 2);
        end
      end
    end
    req_valid = '0;
    req_last  = '0;
    wait_idle("msg");

    // tx_busy held high blocks every grant
    do_reset();
    force_busy = 1'b1;
    req_valid  = 4'b0001;
    req_data   = 32'h000000C3;
    for (int i = 0; i < 4; i++) begin
      step();
      check("busy_block_ready", 32'(req_ready), 32'd0);
    end
    force_busy = 1'b0;
    do_grant("busy_release", 0, 8'hC3);
    req_valid = '0;
    wait_idle("busy");

    // Reset during WAIT_DONE (pointer currently 1)
    req_valid = 4'b0010;
    req_data  = 32'h00007700;
    do_grant("mid", 1, 8'h77);
    req_valid = '0;
    step();
    step();
    check("mid_wait_done", 32'(arb_busy), 32'd1);
    check("mid_tx_busy", 32'(tx_busy), 32'd1);
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    step();
    check("mid_rst_wr_en", 32'(tx_wr_en), 32'd0);
    check("mid_rst_din", 32'(tx_din), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_grant_id", 32'(grant_id), 32'd0);
    check("mid_rst_arb_busy", 32'(arb_busy), 32'd0);
    rst_n = 1'b1;
    do_grant("post_rst", 0, 8'h10);
    req_valid = '0;
    wait_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
